// File: rtl/text_capture_if.sv
// Bus bundle for text_capture: ACIA transmit tap, capture control, hps_io upload port and status.
// The master side drives the stimulus and the slave side is the capture block.
interface text_capture_if #(
    parameter int ADDR_W = 13
);
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              clear;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [15:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W:0]   capture_len;
    logic              full;
    logic              overflow;

    modport slave (
        input  tx_valid, tx_data, clear, ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait, capture_len, full, overflow
    );

    modport master (
        output tx_valid, tx_data, clear, ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait, capture_len, full, overflow
    );
endinterface

// File: rtl/text_capture.sv
// Captures ACIA transmit bytes into a block-RAM buffer and serves them to hps_io uploads.
// Define TEXT_CAPTURE_CRLF_EN to store CR as LF and drop received LF bytes.
//
// state   | meaning
// CAPTURE | ACIA bytes are appended to the buffer; clear is honoured
// UPLOAD  | buffer is frozen and served to ioctl reads; non-NUL bytes set overflow
module text_capture #(
    parameter int          ADDR_W   = 13,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    text_capture_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_UPLOAD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              upload_q;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic              overflow_q, overflow_d;
    logic              wait_q;
    logic [15:0]       addr_q;
    logic [7:0]        din_q;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_accept;
    logic [7:0]        byte_c;
    logic              byte_keep;
    logic              full;
    logic              addr_beyond;

    logic [7:0] mem [DEPTH];

    always_comb begin
        byte_c    = bus.tx_data;
        byte_keep = (bus.tx_data != 8'h00);
`ifdef TEXT_CAPTURE_CRLF_EN
        if (bus.tx_data == 8'h0A) begin
            byte_keep = 1'b0;
        end else if (bus.tx_data == 8'h0D) begin
            byte_c = 8'h0A;
        end
`else
`endif
    end

    assign full        = wr_ptr_q[ADDR_W];
    assign addr_beyond = (addr_q >= 16'(wr_ptr_q));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q[ADDR_W-1:0];
        rd_accept  = 1'b0;
        case (state_q)
            ST_CAPTURE: begin
                if (bus.ioctl_upload && !upload_q) begin
                    state_d = ST_UPLOAD;
                end
                // clear wins over full so a simultaneous byte lands at address 0
                if (bus.clear) begin
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                    if (bus.tx_valid && byte_keep) begin
                        wr_en    = 1'b1;
                        wr_addr  = '0;
                        wr_ptr_d = PTR_ONE;
                    end
                end else if (bus.tx_valid && byte_keep) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            ST_UPLOAD: begin
                if (!bus.ioctl_upload && upload_q) begin
                    state_d = ST_CAPTURE;
                end
                if (bus.tx_valid && byte_keep) begin
                    overflow_d = 1'b1;
                end
                rd_accept = bus.ioctl_rd && !wait_q;
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= byte_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CAPTURE;
            upload_q   <= 1'b0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            wait_q     <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            upload_q   <= bus.ioctl_upload;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            wait_q     <= rd_accept;
            if (rd_accept) begin
                addr_q <= bus.ioctl_addr;
            end
            // a read in flight completes even if the upload ends meanwhile
            if (wait_q) begin
                din_q <= addr_beyond ? PAD_BYTE : mem[addr_q[ADDR_W-1:0]];
            end
        end
    end

    assign bus.ioctl_din   = din_q;
    assign bus.ioctl_wait  = wait_q;
    assign bus.capture_len = wr_ptr_q;
    assign bus.full        = full;
    assign bus.overflow    = overflow_q;
endmodule
